br_lite_local_injector: RTL and testbench
=========================================

// Module: br_lite_local_injector
// PURPOSE
//   Shares the BrLite router LOCAL input port between NREQ on-tile requesters (kernel, DMA, monitors).
//   Round-robin arbitration; stamps source=ADDRESS and a wrapping sequence id; drives the router's
//   4-phase req/ack. Admits a new broadcast only while the router's local_busy is low (one outstanding).
// PARAMETERS
//   NREQ     4       number of local requesters (>=2)
//   ADDRESS  16'h0   router address stamped into flit.source
// PORTS
//   clk_i          in   1                 clock
//   rst_i          in   1                 reset, asynchronous, active-high
//   req_i          in   NREQ              per-requester request, 4-phase (hold until ack_o)
//   flit_i         in   NREQ x br_data_t  per-requester flit; source/id ignored
//   ack_o          out  NREQ              per-requester ack, held until matching req_i drops
//   reject_o       out  1                 valid with ack_o: 1 = request refused (service BR_SVC_CLEAR)
//   br_flit_o      out  br_data_t         flit to router flit_i[BR_LOCAL]
//   br_req_o       out  1                 to router req_i[BR_LOCAL]
//   br_ack_i       in   1                 from router ack_o[BR_LOCAL]
//   local_busy_i   in   1                 router local_busy_o
//   inj_cnt_o      out  32                count of flits accepted by router (wraps)
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, ack_o=0, reject_o=0, br_req_o=0, br_flit_o=0, inj_cnt_o=0,
//     id counter=0, last_grant=NREQ-1 (requester 0 has first priority).
//   FSM: IDLE -> GRANT -> {REQ -> REQ_LOW ->} DONE -> IDLE.
//   IDLE: if req_i!=0 && !local_busy_i -> GRANT; sel = first asserted index after last_grant, wrapping.
//     A request is never granted while local_busy_i=1 (also holds for REJECT-only requests).
//   GRANT (1 cycle): last_grant<=sel; latch flit_i[sel] into out register with source<=ADDRESS,
//     id<=id counter; if flit_i[sel].service==BR_SVC_CLEAR -> DONE with reject flag, else -> REQ.
//   REQ: br_req_o=1, flit register stable; on br_ack_i=1 -> REQ_LOW, inj_cnt_o++, id counter++
//     (wraps at id field width). The router may silently drop (CAM full) and re-arbitrate; keep
//     br_req_o high indefinitely, no timeout.
//   REQ_LOW: br_req_o=0; wait br_ack_i=0 -> DONE.
//   DONE: ack_o[sel]=1, reject_o=flag; when req_i[sel]=0 -> IDLE, reject flag cleared.
//   Latency: req_i rises at cycle 0 (IDLE, busy low) -> br_req_o=1 at cycle 2.
//   br_flit_o changes only in GRANT; all outputs registered/state-decoded, no comb path req_i->br_req_o.
//   Id counter width = $bits of br_data_t id field; rejected requests consume no id.
//   Requester dropping req_i before ack_o: ignored; injection completes, DONE exits on req_i low.
//   Non-selected requesters' flit_i changes have no effect after GRANT.
//   local_busy_i rising mid-handshake does not abort the current transfer.
// TESTING
//   Single req_i[2], service ALL, payload 32'hA5 -> br_req_o at cycle 2, br_flit_o.source=ADDRESS,
//     id=0; br_ack_i pulse -> ack_o[2]=1, reject_o=0, inj_cnt_o=1.
//   req_i=4'b1111 held, router acks, busy held low -> grant order 0,1,2,3,0; ids 0..4.
//   local_busy_i=1 with req_i[1] pending 200 cycles -> br_req_o stays 0; drop busy -> grant in 1 cycle.
//   req_i[3] with service CLEAR -> no br_req_o, ack_o[3]=1, reject_o=1, inj_cnt_o unchanged.
//   Router withholds br_ack_i 500 cycles (CAM full) -> br_req_o and br_flit_o stable throughout.
//   rst_i asserted while in REQ -> br_req_o, ack_o, inj_cnt_o = 0 same cycle; next grant is requester 0.

Source files
------------

// File: rtl/br_lite_local_injector_if.sv
// Flit types shared by the BrLite local injector and its requesters, plus the
// bundled requester/router signal interface.
package br_lite_pkg;
    localparam int BR_ID_W = 5;

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_CLEAR = 2'd2,
        BR_SVC_ACK   = 2'd3
    } br_svc_t;

    typedef struct packed {
        br_svc_t              service;
        logic [BR_ID_W-1:0]   id;
        logic [15:0]          source;
        logic [31:0]          payload;
    } br_data_t;
endpackage

interface br_lite_local_injector_if #(parameter int NREQ = 4);
    import br_lite_pkg::*;

    logic [NREQ-1:0] req_i;
    br_data_t        flit_i [NREQ];
    logic [NREQ-1:0] ack_o;
    logic            reject_o;
    br_data_t        br_flit_o;
    logic            br_req_o;
    logic            br_ack_i;
    logic            local_busy_i;
    logic [31:0]     inj_cnt_o;

    // slave: the injector itself; master: requesters plus router side
    modport slave (
        input  req_i, flit_i, br_ack_i, local_busy_i,
        output ack_o, reject_o, br_flit_o, br_req_o, inj_cnt_o
    );

    modport master (
        output req_i, flit_i, br_ack_i, local_busy_i,
        input  ack_o, reject_o, br_flit_o, br_req_o, inj_cnt_o
    );
endinterface

// File: rtl/br_lite_local_injector.sv
// Round-robin arbiter sharing the BrLite router LOCAL input among NREQ on-tile
// requesters; stamps source/id and runs the router's 4-phase req/ack.
//
// state   | meaning
// IDLE    | wait for a request while router local_busy is low
// GRANT   | latch selected flit, stamp source/id, decide reject
// REQ     | br_req_o high, wait for router ack (no timeout)
// REQ_LOW | br_req_o low, wait for router ack to drop
// DONE    | ack selected requester until its req_i drops
module br_lite_local_injector
    import br_lite_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter logic [15:0] ADDRESS = 16'h0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    br_lite_local_injector_if.slave   bus
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        REQ     = 3'd2,
        REQ_LOW = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [SW-1:0]        last_q, last_d;
    br_data_t             flit_q, flit_d;
    logic [BR_ID_W-1:0]   id_q, id_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 rej_q, rej_d;

    logic [SW-1:0]        pick;
    logic [SW-1:0]        idx;
    logic                 found;
    logic [NREQ-1:0]      sel_oh;

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        pick  = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = SW'((int'(last_q) + i) % NREQ);
            if (!found && bus.req_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        flit_d  = flit_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        rej_d   = rej_q;

        case (state_q)
            IDLE: begin
                if (found && !bus.local_busy_i) begin
                    sel_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                last_d        = sel_q;
                flit_d        = bus.flit_i[sel_q];
                flit_d.source = ADDRESS;
                flit_d.id     = id_q;
                if (bus.flit_i[sel_q].service == BR_SVC_CLEAR) begin
                    rej_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A router drop (CAM full) just means waiting longer here.
                if (bus.br_ack_i) begin
                    cnt_d   = cnt_q + 32'd1;
                    id_d    = id_q + 1'b1;
                    state_d = REQ_LOW;
                end
            end
            REQ_LOW: begin
                if (!bus.br_ack_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.req_i[sel_q]) begin
                    rej_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SW'(NREQ - 1);
            flit_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            flit_q  <= flit_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
    end

    assign bus.ack_o     = (state_q == DONE) ? sel_oh : '0;
    assign bus.reject_o  = (state_q == DONE) && rej_q;
    assign bus.br_req_o  = (state_q == REQ);
    assign bus.br_flit_o = flit_q;
    assign bus.inj_cnt_o = cnt_q;

endmodule

// File: tb/tb_br_lite_local_injector.sv
// Self-checking bench for br_lite_local_injector: directed scenarios followed by
// randomized traffic against a round-robin / counter reference model.
module tb_br_lite_local_injector;
    import br_lite_pkg::*;

    localparam int          NREQ = 4;
    localparam logic [15:0] ADDR = 16'h0042;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    br_lite_local_injector_if #(.NREQ(NREQ)) bus();

    br_lite_local_injector #(.NREQ(NREQ), .ADDRESS(ADDR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    br_data_t        fl [NREQ];
    logic [NREQ-1:0] mask;
    int              m_last, m_id, m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = NREQ - 1;
        m_id   = 0;
        m_cnt  = 0;
    endtask

    // Next grant: first pending requester after the previous winner, wrapping.
    function automatic int rr(input logic [NREQ-1:0] m, input int last);
        logic [NREQ-1:0] rot;
        for (int i = 1; i <= NREQ; i++) begin
            rot = m >> ((last + i) % NREQ);
            if (rot[0]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // source/id are filled with junk: the injector must overwrite them.
    task automatic set_flit(input int i, input br_svc_t s, input logic [31:0] p);
        br_data_t f;
        f.service = s;
        f.payload = p;
        f.id      = BR_ID_W'($urandom);
        f.source  = 16'($urandom);
        fl[i] = f;
        bus.flit_i[i] = f;
    endtask

    task automatic raise(input int i);
        mask = mask | (NREQ'(1) << i);
        bus.req_i = mask;
    endtask

    task automatic serve(input int g, input int delay, input bit early);
        int              n;
        br_data_t        expf;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << g;
        n = 0;
        while (bus.br_req_o !== 1'b1 && bus.ack_o === '0 && n < 20) begin
            step();
            n++;
        end
        if (fl[g].service == BR_SVC_CLEAR) begin
            check("rej_no_br_req", bus.br_req_o, 1'b0);
            check("rej_ack", bus.ack_o, oh);
            check("rej_flag", bus.reject_o, 1'b1);
            check("rej_cnt", bus.inj_cnt_o, 32'(m_cnt));
        end else begin
            expf        = fl[g];
            expf.source = ADDR;
            expf.id     = BR_ID_W'(m_id % (1 << BR_ID_W));
            check("br_req", bus.br_req_o, 1'b1);
            check("br_flit", bus.br_flit_o, expf);
            if (early) begin
                mask = mask & ~oh;
                bus.req_i = mask;
            end
            repeat (delay) step();
            bus.br_ack_i = 1'b1;
            step();
            m_cnt++;
            m_id++;
            check("br_req_low", bus.br_req_o, 1'b0);
            check("inj_cnt", bus.inj_cnt_o, 32'(m_cnt));
            bus.br_ack_i = 1'b0;
            n = 0;
            while (bus.ack_o === '0 && n < 10) begin
                step();
                n++;
            end
            check("ack", bus.ack_o, oh);
            check("reject0", bus.reject_o, 1'b0);
        end
        m_last = g;
        mask = mask & ~oh;
        bus.req_i = mask;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.ack_o !== '0 && n < 10);
        check("ack_drop", bus.ack_o, 4'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mask != '0 && guard < 16) begin
            serve(rr(mask, m_last), 0, 1'b0);
            guard++;
        end
    endtask

    initial begin
        bit              seen;
        int              n;
        int              g;
        br_data_t        held;
        logic [NREQ-1:0] nw;

        rst              = 1'b1;
        mask             = '0;
        bus.req_i        = '0;
        bus.br_ack_i     = 1'b0;
        bus.local_busy_i = 1'b0;
        for (int i = 0; i < NREQ; i++) set_flit(i, BR_SVC_ALL, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // reset values
        check("rst_ack", bus.ack_o, 4'b0);
        check("rst_reject", bus.reject_o, 1'b0);
        check("rst_br_req", bus.br_req_o, 1'b0);
        check("rst_flit", bus.br_flit_o, br_data_t'('0));
        check("rst_cnt", bus.inj_cnt_o, 32'h0);
        rst = 1'b0;
        step();

        // single requester, latency to br_req_o
        set_flit(2, BR_SVC_ALL, 32'hA5);
        raise(2);
        step();
        check("lat_c1", bus.br_req_o, 1'b0);
        step();
        check("lat_c2", bus.br_req_o, 1'b1);
        serve(2, 0, 1'b0);

        // all four held: fair rotation and consecutive ids
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) set_flit(i, BR_SVC_ALL, 32'h100 + i);
        mask = 4'hF;
        bus.req_i = mask;
        for (int k = 0; k < 5; k++) begin
            g = rr(mask, m_last);
            serve(g, k, 1'b0);
            raise(g);
        end
        drain();

        // router busy blocks admission
        bus.local_busy_i = 1'b1;
        set_flit(1, BR_SVC_ALL, 32'hB0B0_0001);
        raise(1);
        seen = 1'b0;
        repeat (200) begin
            step();
            if (bus.br_req_o !== 1'b0 || bus.ack_o !== '0) seen = 1'b1;
        end
        check("busy_hold", seen, 1'b0);
        bus.local_busy_i = 1'b0;
        step();
        check("busy_release_c1", bus.br_req_o, 1'b0);
        step();
        check("busy_release_c2", bus.br_req_o, 1'b1);
        serve(1, 2, 1'b0);

        // CLEAR request: also held off by busy, then rejected without injection
        bus.local_busy_i = 1'b1;
        set_flit(3, BR_SVC_CLEAR, 32'hDEAD);
        raise(3);
        seen = 1'b0;
        repeat (20) begin
            step();
            if (bus.br_req_o !== 1'b0 || bus.ack_o !== '0) seen = 1'b1;
        end
        check("busy_clear_hold", seen, 1'b0);
        bus.local_busy_i = 1'b0;
        serve(3, 0, 1'b0);

        // router withholds ack for 500 cycles
        set_flit(0, BR_SVC_ALL, 32'hCAFE);
        raise(0);
        n = 0;
        while (bus.br_req_o !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("cam_req_up", bus.br_req_o, 1'b1);
        held = bus.br_flit_o;
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (bus.br_req_o !== 1'b1 || bus.br_flit_o !== held) seen = 1'b1;
            if (k == 100) begin
                set_flit(2, BR_SVC_ALL, $urandom);
                raise(2);
            end
            if (k == 300) set_flit(2, BR_SVC_TGT, $urandom);
        end
        check("cam_stable", seen, 1'b0);
        drain();

        // reset while in REQ
        set_flit(0, BR_SVC_ALL, $urandom);
        raise(0);
        n = 0;
        while (bus.br_req_o !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("pre_rst_req", bus.br_req_o, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_br_req", bus.br_req_o, 1'b0);
        check("midrst_ack", bus.ack_o, 4'b0);
        check("midrst_cnt", bus.inj_cnt_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        set_flit(2, BR_SVC_ALL, $urandom);
        raise(2);
        g = rr(mask, m_last);
        serve(g, 1, 1'b0);
        drain();

        // randomized traffic (includes id wrap and early req drops)
        for (int it = 0; it < 70; it++) begin
            nw = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (nw[i] && !mask[i]) begin
                    set_flit(i, br_svc_t'($urandom_range(0, 3)), $urandom);
                    raise(i);
                end
            end
            if (mask == '0) begin
                g = $urandom_range(0, NREQ - 1);
                set_flit(g, br_svc_t'($urandom_range(0, 3)), $urandom);
                raise(g);
            end
            g = rr(mask, m_last);
            serve(g, $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
